uart_tx_periph: RTL and testbench
=================================

# uart_tx_periph

Memory-mapped UART transmitter on the CPU data bus peripheral region (address bit 31 set), beside the LED/status registers. Decodes one-cycle dBus commands, buffers bytes in a small FIFO and serialises them 8N1 on `txd`. Reads return data exactly one cycle after the command, so the existing single-cycle dBus read-merge path needs no wait states.

## Interface
- `BAUD_DIV`, default 434: reset value of the divisor, in clock cycles per bit; 50 MHz / 115200.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of 2, ≥ 2.
- `clk` in 1: sole clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sel` in 1: command strobe; equals dBus cmd valid AND address[31] AND this block's address decode.
- `wr` in 1: 1 = write, 0 = read.
- `addr` in 2: word index, taken from dBus address[3:2].
- `wdata` in 32: write data.
- `rdata` out 32: registered read data.
- `txd` out 1: serial output; idle high.

## Operation
- Register map, by `addr`:
  - 0, DATA: a write pushes `wdata[7:0]`; a read returns 0.
  - 1, STATUS: read returns bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[7:4] FIFO level (0..FIFO_DEPTH). A write with `wdata[3]`=1 clears overflow; other bits are ignored.
  - 2, DIV: R/W, bits[15:0]; bits[31:16] read 0. A written value < 2 is stored as 2.
  - 3: reads 0; writes are ignored.
- Push to DATA while full: byte dropped, FIFO unchanged, overflow set. Full is evaluated before any same-cycle pop, so the push is dropped even if the FIFO pops that cycle.
- Overflow set and cleared in the same cycle: set wins.
- FIFO is circular; read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Tx FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head into the shift register, latch DIV into the bit timer reload, and go to START.
  - START: `txd`=0 for one bit period, then DATA.
  - DATA: `txd` = shift[0], LSB first; 8 bit periods, shifting right after each; then STOP.
  - STOP: `txd`=1 for one bit period, then IDLE. A frame still pending in the FIFO may pop on the IDLE cycle, so back-to-back frames have exactly one idle clock between stop and start.
- A bit period is the latched divisor value D in cycles; the timer counts D-1 down to 0. Writing DIV mid-frame affects only the next frame.
- A read latches `rdata` on the same edge as the command. Status reflects state before that edge's updates. `rdata` otherwise holds its value.

## Timing
- Reset (async assert, any state): `txd`=1, `rdata`=0, FIFO empty, overflow=0, DIV=BAUD_DIV, FSM IDLE. An in-flight frame is truncated with `txd` high immediately.
- Reset deassertion is taken synchronously by the surrounding design; the first command is accepted on the first edge with `reset_n` high.
- Read latency: `rdata` valid in the cycle after the `sel` cycle.
- Write at edge E into an empty FIFO with the FSM IDLE: FIFO non-empty after E; pop at E+1; `txd` low from E+1 for D cycles.
- Frame length = 10·D cycles, plus 1 IDLE cycle between consecutive frames.
- No backpressure. Every `sel` cycle is a complete transaction.

## Test plan
- Reset: hold `reset_n`=0 → `txd`=1, `rdata`=0. Then read STATUS → 0x00000002 (empty) and DIV → 434.
- Single byte: write DIV=4, then DATA=0x55 → `txd` low from edge E+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high. A STATUS read during the frame has bit2=1.
- Overflow: with DIV=100, write 10 bytes 0x00..0x09 back-to-back → first byte pops. STATUS reads level=8, full=1, overflow=1. Output sequence is 0x00..0x08; 0x09 is lost. Write STATUS with bit3=1 → overflow=0.
- Back-to-back: DIV=2, write 0xA5 and 0x3C → two frames, 20 cycles each plus exactly 1 idle-high cycle between them. Status returns empty=1, busy=0 after the second stop.
- DIV edge cases: write DIV=0 → reads back 2. Write DIV=8 during a DIV=2 frame → current frame stays at 2 cycles/bit; the next frame runs at 8.
- Reset mid-frame: assert `reset_n` during DATA → `txd`=1 asynchronously, FIFO empty. After release, no further `txd` activity without new writes.

Source files
------------

// File: rtl/uart_tx_periph_if.sv
// dBus peripheral command port: one-cycle command strobe, registered read data.
interface uart_tx_periph_if;
  logic        sel;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, wr, addr, wdata, input rdata);
  modport slave  (input sel, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter; rdata is registered one cycle after sel.
// No backpressure: every sel cycle completes, pushes into a full FIFO are dropped and flagged.
module uart_tx_periph #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_tx_periph_if.slave dBus,
  output logic            txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;
  txState_t state, stateNext;

  logic [7:0]  fifoMem [FIFO_DEPTH];
  logic [AW:0] wrPtr, rdPtr, level;
  logic        full, empty, overflow;
  logic [15:0] divReg, divLatch, bitTimer;
  logic [2:0]  bitCnt;
  logic [7:0]  shiftReg;
  logic [31:0] rdataQ, statusWord;
  logic        push, pushOk, pop, ovfClr, divWr, rdCmd, timerDone;
  logic        unusedWdata;

  assign level      = wrPtr - rdPtr;
  assign full       = (level == DEPTH_CNT);
  assign empty      = (level == '0);
  assign push       = dBus.sel & dBus.wr & (dBus.addr == 2'd0);
  assign pushOk     = push & ~full;
  assign pop        = (state == IDLE) & ~empty;
  assign ovfClr     = dBus.sel & dBus.wr & (dBus.addr == 2'd1) & dBus.wdata[3];
  assign divWr      = dBus.sel & dBus.wr & (dBus.addr == 2'd2);
  assign rdCmd      = dBus.sel & ~dBus.wr;
  assign timerDone  = (bitTimer == '0);
  assign statusWord = {24'd0, 4'(level), overflow, state != IDLE, empty, full};
  assign dBus.rdata = rdataQ;
  assign unusedWdata = &{1'b0, dBus.wdata[31:16]};

  // Full is judged on the pre-edge level, so a push is dropped even if a pop happens this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_ONE;
      if (pop)    rdPtr <= rdPtr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtr[AW-1:0]] <= dBus.wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      divReg   <= 16'(BAUD_DIV);
      rdataQ   <= '0;
    end else begin
      if (push && full) overflow <= 1'b1;
      else if (ovfClr)  overflow <= 1'b0;
      if (divWr)
        divReg <= (dBus.wdata[15:0] < 16'd2) ? 16'd2 : dBus.wdata[15:0];
      if (rdCmd) begin
        case (dBus.addr)
          2'd1:    rdataQ <= statusWord;
          2'd2:    rdataQ <= {16'd0, divReg};
          default: rdataQ <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (!empty) stateNext = START;
      START:   if (timerDone) stateNext = DATA;
      DATA:    if (timerDone && bitCnt == 3'd7) stateNext = STOP;
      STOP:    if (timerDone) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // txd decodes straight from state so reset forces the line high without waiting for a clock.
  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = shiftReg[0];
      default: txd = 1'b1;
    endcase
  end

  // Divisor is sampled at pop so DIV writes mid-frame only affect the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shiftReg <= '0;
      divLatch <= 16'd2;
      bitTimer <= '0;
      bitCnt   <= '0;
    end else if (pop) begin
      shiftReg <= fifoMem[rdPtr[AW-1:0]];
      divLatch <= divReg;
      bitTimer <= divReg - 16'd1;
      bitCnt   <= '0;
    end else if (state != IDLE) begin
      if (timerDone) begin
        bitTimer <= divLatch - 16'd1;
        if (state == DATA) begin
          shiftReg <= {1'b0, shiftReg[7:1]};
          bitCnt   <= bitCnt + 3'd1;
        end
      end else begin
        bitTimer <= bitTimer - 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: queue-based register/FIFO model plus a txd line monitor that
// decodes each frame and checks its bits, bit period and start cycle.
module tb_uart_tx_periph;
  localparam int DEPTH = 8;

  typedef struct {
    logic [7:0] dat;
    int         pushCyc;
  } frame_t;

  logic clk;
  logic reset_n;
  logic txd;
  uart_tx_periph_if bus();

  uart_tx_periph #(.BAUD_DIV(434), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .dBus(bus), .txd(txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference model state
  frame_t      expQ[$];
  int          accepted = 0;
  int          started = 0;
  int          prevEnd = -1000;
  logic        modelOvf = 1'b0;
  logic [15:0] modelDiv = 16'd434;
  logic        monBusy = 1'b0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    int lvl;
    lvl = accepted - started;
    return {24'd0, 4'(lvl), modelOvf, monBusy, lvl == 0, lvl == DEPTH};
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd1:    return modelStatus();
      2'd2:    return {16'd0, modelDiv};
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    expQ.delete();
    accepted = 0;
    started  = 0;
    prevEnd  = -1000;
    modelOvf = 1'b0;
    modelDiv = 16'd434;
  endtask

  // Commands are driven after a falling edge; the model decision is taken 1ns later so the
  // line monitor has already accounted for frames that began on the previous rising edge.
  task automatic busWrite(input logic [1:0] a, input logic [31:0] v);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = v;
    #1;
    if (a == 2'd0) begin
      if (accepted - started >= DEPTH) modelOvf = 1'b1;
      else begin
        accepted++;
        expQ.push_back('{dat: v[7:0], pushCyc: cyc + 1});
      end
    end else if (a == 2'd1 && v[3]) begin
      modelOvf = 1'b0;
    end
    @(negedge clk);
    bus.sel = 1'b0;
    if (a == 2'd2) begin
      #1;
      modelDiv = (v[15:0] < 16'd2) ? 16'd2 : v[15:0];
    end
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] got, output logic [31:0] exp);
    bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = a; bus.wdata = $urandom;
    #1;
    exp = modelRead(a);
    @(negedge clk);
    bus.sel = 1'b0;
    got = bus.rdata;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((accepted != started || monBusy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkEq("drainInTime", 32'(n < budget), 32'd1);
  endtask

  task automatic waitBusy(input int budget);
    int n;
    n = 0;
    while (!monBusy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkEq("frameBegan", 32'(n < budget), 32'd1);
  endtask

  // Line monitor: every frame is 10 bit periods of the divisor in force when it starts,
  // and starts at max(push edge + 1, previous stop end + 2).
  initial begin : lineMonitor
    frame_t     f;
    int         d, bad, expStart, startCyc, bitIdx;
    logic [7:0] seen;
    logic       expBit, aborted, haveExp;
    forever begin
      @(negedge clk);
      if (reset_n && txd === 1'b0) begin
        startCyc = cyc;
        d = int'(modelDiv);
        monBusy = 1'b1;
        started++;
        haveExp = (expQ.size() > 0);
        checkEq("frameExpected", 32'(haveExp), 32'd1);
        if (haveExp) f = expQ.pop_front();
        else begin
          f.dat = 8'h00;
          f.pushCyc = startCyc - 1;
        end
        expStart = (f.pushCyc + 1 > prevEnd + 2) ? f.pushCyc + 1 : prevEnd + 2;
        bad = 0; seen = '0; aborted = 1'b0;
        for (int i = 0; i < 10 * d; i++) begin
          if (i > 0) @(negedge clk);
          if (!reset_n) begin
            aborted = 1'b1;
            break;
          end
          bitIdx = i / d;
          if (bitIdx == 0)      expBit = 1'b0;
          else if (bitIdx == 9) expBit = 1'b1;
          else                  expBit = f.dat[bitIdx-1];
          if (txd !== expBit) bad++;
          if (bitIdx >= 1 && bitIdx <= 8 && (i % d) == d / 2) seen[bitIdx-1] = txd;
        end
        if (aborted) monBusy = 1'b0;
        else begin
          checkEq("frameStart", 32'(startCyc), 32'(expStart));
          checkEq("frameByte", 32'(seen), 32'(f.dat));
          checkEq("frameShape", 32'(bad), 32'd0);
          prevEnd = cyc;
          @(negedge clk);
          monBusy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] got, exp;
    int          op;
    logic [1:0]  ra;
    reset_n = 1'b0;
    bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
    repeat (3) @(negedge clk);
    checkEq("rstTxd", 32'(txd), 32'd1);
    checkEq("rstRdata", bus.rdata, 32'd0);
    reset_n = 1'b1;
    busRead(2'd1, got, exp);
    checkEq("rstStatus", got, 32'h2);
    busRead(2'd2, got, exp);
    checkEq("rstDiv", got, 32'd434);

    // Single byte at 4 cycles/bit
    busWrite(2'd2, 32'd4);
    busWrite(2'd0, 32'h55);
    repeat (10) @(negedge clk);
    busRead(2'd1, got, exp);
    checkEq("busyBit", 32'(got[2]), 32'd1);
    checkEq("midFrameStatus", got, exp);
    waitDrain(200);

    // Overflow: ten back-to-back pushes, only nine fit
    busWrite(2'd2, 32'd100);
    for (int k = 0; k < 10; k++) busWrite(2'd0, 32'(k));
    busRead(2'd1, got, exp);
    checkEq("ovfStatus", got, 32'h8D);
    checkEq("ovfStatusModel", got, exp);
    busWrite(2'd1, 32'h8);
    busRead(2'd1, got, exp);
    checkEq("ovfCleared", got, 32'h85);
    waitDrain(12000);

    // Back-to-back frames at 2 cycles/bit
    busWrite(2'd2, 32'd2);
    busWrite(2'd0, 32'hA5);
    busWrite(2'd0, 32'h3C);
    waitDrain(200);
    busRead(2'd1, got, exp);
    checkEq("b2bIdleStatus", got, 32'h2);

    // Divisor clamp and mid-frame divisor change
    busWrite(2'd2, 32'd0);
    busRead(2'd2, got, exp);
    checkEq("divClamp0", got, 32'd2);
    busWrite(2'd2, 32'h0001_0001);
    busRead(2'd2, got, exp);
    checkEq("divClamp1", got, exp);
    busWrite(2'd2, 32'd2);
    busWrite(2'd0, 32'h5A);
    repeat (5) @(negedge clk);
    busWrite(2'd2, 32'd8);
    busWrite(2'd0, 32'hC3);
    waitDrain(400);

    // Randomised mix of pushes, register writes and reads
    busWrite(2'd2, 32'd3);
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 9);
      if (op < 5)       busWrite(2'd0, $urandom);
      else if (op == 5) busWrite(2'd2, {16'($urandom), 16'($urandom_range(0, 5))});
      else if (op == 6) busWrite(2'd1, $urandom);
      else if (op == 7) busWrite(2'd3, $urandom);
      else begin
        ra = 2'($urandom_range(0, 3));
        busRead(ra, got, exp);
        checkEq("rndRead", got, exp);
      end
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    waitDrain(5000);
    busRead(2'd1, got, exp);
    checkEq("rndFinalStatus", got, exp);

    // Reset in the middle of a frame with another byte still queued
    busWrite(2'd2, 32'd4);
    busWrite(2'd0, 32'h00);
    busWrite(2'd0, 32'hFF);
    waitBusy(50);
    repeat (10) @(negedge clk);
    checkEq("preRstTxd", 32'(txd), 32'd0);
    #2 reset_n = 1'b0;
    #1 checkEq("asyncRstTxd", 32'(txd), 32'd1);
    repeat (3) @(negedge clk);
    checkEq("inRstTxd", 32'(txd), 32'd1);
    modelReset();
    reset_n = 1'b1;
    busRead(2'd1, got, exp);
    checkEq("postRstStatus", got, 32'h2);
    busRead(2'd2, got, exp);
    checkEq("postRstDiv", got, 32'd434);
    repeat (100) @(negedge clk);
    checkEq("postRstQuiet", 32'(started), 32'd0);
    checkEq("leftoverFrames", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
